rom_overlay_loader: RTL and testbench



---
 rtl/rom_overlay_loader_if.sv | 15 +
 rtl/rom_overlay_loader.sv | 181 ++++++++++++++++++
 tb/tb_rom_overlay_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_overlay_loader_if.sv
// rom_overlay_loader_if
//   Byte-stream valid/ready handshake feeding the ROM-overlay loader.
//   in_data  : stream byte
//   in_valid : in_data valid (source side)
//   in_ready : loader accepts byte (sink side)
//   modport master : byte source (ESP32 command path / testbench)
//   modport slave  : byte sink (the loader)
interface rom_overlay_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rom_overlay_loader.sv
// rom_overlay_loader
//   Loads a framed byte stream into the 2K x 8 Z80 ROM-overlay RAM through
//   its second port. Frame: SYNC, addr lo/hi, len lo/hi, len payload bytes,
//   checksum byte. The 8-bit sum of every byte after SYNC must be zero.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   in_if (slave)  : byte stream in_data / in_valid / in_ready
//   abort          : drop the current frame
//   ram_ad/ram_din/ram_we/ram_ce : RAM port-B write side (ce mirrors we)
//   busy           : frame in progress
//   done / err     : one-cycle frame outcome pulses
//   err_code       : 0 none, 1 bad header, 2 checksum, 3 abort
//   overlay_en     : image valid, Z80 side may map the overlay
module rom_overlay_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         DEPTH     = 2048
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rom_overlay_loader_if.slave    in_if,
    input  logic                   abort,
    output logic [10:0]            ram_ad,
    output logic [7:0]             ram_din,
    output logic                   ram_we,
    output logic                   ram_ce,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   overlay_en
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
    localparam logic [12:0] DEPTH13 = 13'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CSUM
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] ptr, ptr_nxt;          // next RAM write address
    logic        addr_bad, addr_bad_nxt; // addr[15:11] non-zero
    logic [7:0]  len_lo, len_lo_nxt;
    logic [11:0] rem, rem_nxt;          // payload bytes still expected
    logic [7:0]  csum, csum_nxt;
    logic [10:0] ad_nxt;
    logic [7:0]  din_nxt;
    logic        we_nxt, done_nxt, err_nxt, ov_nxt;
    logic [1:0]  code_nxt;

    logic        acc;
    logic [15:0] len_full;
    logic [12:0] end_sum;
    logic        hdr_bad;

    // Never back-pressures except while abort is held or in reset.
    assign in_if.in_ready = reset_n & ~abort;
    assign acc            = in_if.in_valid & in_if.in_ready;

    assign busy   = (state != IDLE);
    assign ram_ce = ram_we;

    // Header validation uses the LEN_HI byte directly from the stream.
    // The 13-bit end sum only matters once len <= DEPTH, so truncation is safe.
    assign len_full = {in_if.in_data, len_lo};
    assign end_sum  = {2'b00, ptr} + len_full[12:0];
    assign hdr_bad  = addr_bad || (len_full == 16'd0) || (len_full > DEPTH16) ||
                      (end_sum > DEPTH13);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            addr_bad   <= 1'b0;
            len_lo     <= '0;
            rem        <= '0;
            csum       <= '0;
            ram_ad     <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            overlay_en <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            addr_bad   <= addr_bad_nxt;
            len_lo     <= len_lo_nxt;
            rem        <= rem_nxt;
            csum       <= csum_nxt;
            ram_ad     <= ad_nxt;
            ram_din    <= din_nxt;
            ram_we     <= we_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            err_code   <= code_nxt;
            overlay_en <= ov_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        addr_bad_nxt = addr_bad;
        len_lo_nxt   = len_lo;
        rem_nxt      = rem;
        csum_nxt     = csum;
        ad_nxt       = ram_ad;
        din_nxt      = ram_din;
        we_nxt       = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        code_nxt     = err_code;
        ov_nxt       = overlay_en;

        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            code_nxt  = 2'd3;
            ov_nxt    = 1'b0;
        end else if (acc) begin
            if (state != IDLE)
                csum_nxt = csum + in_if.in_data;
            case (state)
                IDLE: begin
                    if (in_if.in_data == SYNC_BYTE) begin
                        state_nxt = ADDR_LO;
                        ov_nxt    = 1'b0;
                        code_nxt  = 2'd0;
                        csum_nxt  = 8'h00;
                    end
                end
                ADDR_LO: begin
                    ptr_nxt[7:0] = in_if.in_data;
                    state_nxt    = ADDR_HI;
                end
                ADDR_HI: begin
                    ptr_nxt[10:8] = in_if.in_data[2:0];
                    addr_bad_nxt  = |in_if.in_data[7:3];
                    state_nxt     = LEN_LO;
                end
                LEN_LO: begin
                    len_lo_nxt = in_if.in_data;
                    state_nxt  = LEN_HI;
                end
                LEN_HI: begin
                    if (hdr_bad) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd1;
                    end else begin
                        rem_nxt   = len_full[11:0];
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    we_nxt  = 1'b1;
                    ad_nxt  = ptr;
                    din_nxt = in_if.in_data;
                    ptr_nxt = ptr + 11'd1;
                    rem_nxt = rem - 12'd1;
                    if (rem == 12'd1)
                        state_nxt = CSUM;
                end
                CSUM: begin
                    state_nxt = IDLE;
                    if (8'(csum + in_if.in_data) == 8'h00) begin
                        done_nxt = 1'b1;
                        ov_nxt   = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                        code_nxt = 2'd2;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_overlay_loader.sv
module tb_rom_overlay_loader;

    logic        clk;
    logic        reset_n;
    logic        abort;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din;
    logic        ram_we, ram_ce, busy, done, err, overlay_en;
    logic [1:0]  err_code;

    rom_overlay_loader_if sif();

    rom_overlay_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_if      (sif),
        .abort      (abort),
        .ram_ad     (ram_ad),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_ce     (ram_ce),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .overlay_en (overlay_en)
    );

    typedef struct {
        int          cyc;
        logic [10:0] ad;
        logic [7:0]  d;
    } wr_t;

    wr_t        wq[$];
    wr_t        mw;
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         mon_on = 0;
    logic [7:0] sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard,
    // including the cycle it was predicted for.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("ram_ce", {31'd0, ram_ce}, {31'd0, ram_we});
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("unexp_we", 32'd1, 32'd0);
                end else begin
                    mw = wq.pop_front();
                    chk("wr_cyc", mw.cyc, cyc);
                    chk("wr_ad", {21'd0, ram_ad}, {21'd0, mw.ad});
                    chk("wr_din", {24'd0, ram_din}, {24'd0, mw.d});
                end
            end
        end
    end

    // Offer one byte after 'gap' idle cycles; it is accepted on the next edge.
    task automatic send(input logic [7:0] b, input int gap, input bit wr, input logic [10:0] ad);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        sum = sum + b;
        if (wr) wq.push_back('{cyc, ad, b});
    endtask

    task automatic frame(input logic [15:0] addr, input logic [15:0] len, input int npay,
                         input logic [7:0] cdelta, input int maxgap, input bit fixed,
                         input logic [1:0] code);
        logic [7:0] b;
        send(8'hA5, 0, 0, 0);
        sum = 8'h00;
        @(negedge clk);
        chk("busy_hi", {31'd0, busy}, 32'd1);
        send(addr[7:0],  $urandom_range(maxgap, 0), 0, 0);
        send(addr[15:8], $urandom_range(maxgap, 0), 0, 0);
        send(len[7:0],   $urandom_range(maxgap, 0), 0, 0);
        send(len[15:8],  $urandom_range(maxgap, 0), 0, 0);
        for (int i = 0; i < npay; i++) begin
            b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            send(b, $urandom_range(maxgap, 0), 1, 11'(addr[10:0] + 11'(i)));
        end
        if (code != 2'd1) begin
            b = 8'h00 - sum;
            b = b + cdelta;
            send(b, $urandom_range(maxgap, 0), 0, 0);
        end
        @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, code == 2'd0});
        chk("err", {31'd0, err}, {31'd0, code != 2'd0});
        chk("err_code", {30'd0, err_code}, {30'd0, code});
        chk("overlay_en", {31'd0, overlay_en}, {31'd0, code == 2'd0});
        chk("busy_lo", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("pulse_done", {31'd0, done}, 32'd0);
        chk("pulse_err", {31'd0, err}, 32'd0);
        chk("wq_empty", wq.size(), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        abort        = 1'b0;
        sif.in_data  = 8'h00;
        sif.in_valid = 1'b0;
        sum          = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_on  = 1;
        @(negedge clk);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ad", {21'd0, ram_ad}, 32'd0);
        chk("rst_din", {24'd0, ram_din}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_ov", {31'd0, overlay_en}, 32'd0);
        chk("rst_rdy", {31'd0, sif.in_ready}, 32'd1);

        // good frame: 0x100 <- 11 22 33
        frame(16'h0100, 16'd3, 3, 8'h00, 0, 1, 2'd0);
        // same frame with a wrong checksum
        frame(16'h0100, 16'd3, 3, 8'h01, 0, 1, 2'd2);

        // abort while idle is ignored; err_code keeps its value
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_err", {31'd0, err}, 32'd0);
        chk("idle_abort_code", {30'd0, err_code}, 32'd2);

        // bad headers
        frame(16'h07FF, 16'd2,      0, 8'h00, 0, 0, 2'd1);
        frame(16'h0000, 16'd0,      0, 8'h00, 0, 0, 2'd1);
        frame(16'h0000, 16'h0801,   0, 8'h00, 0, 0, 2'd1);
        frame(16'h0800, 16'd1,      0, 8'h00, 0, 0, 2'd1);
        // legal boundary: last byte of RAM
        frame(16'h07FF, 16'd1,      1, 8'h00, 0, 0, 2'd0);

        // garbage ahead of a frame with random in_valid gaps
        send(8'h00, 0, 0, 0);
        send(8'h5A, 1, 0, 0);
        send(8'hFF, 0, 0, 0);
        @(negedge clk);
        chk("garbage_busy", {31'd0, busy}, 32'd0);
        frame(16'h0200, 16'd8, 8, 8'h00, 3, 0, 2'd0);

        // abort after 2 of 3 payload bytes; the byte offered with abort is refused
        send(8'hA5, 0, 0, 0);
        send(8'h10, 0, 0, 0);
        send(8'h00, 0, 0, 0);
        send(8'h03, 0, 0, 0);
        send(8'h00, 0, 0, 0);
        send(8'hC1, 0, 1, 11'h010);
        send(8'hC2, 0, 1, 11'h011);
        abort        = 1'b1;
        sif.in_data  = 8'h55;
        sif.in_valid = 1'b1;
        @(negedge clk);
        chk("rdy_abort", {31'd0, sif.in_ready}, 32'd0);
        @(posedge clk); #1;
        abort        = 1'b0;
        sif.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_err", {31'd0, err}, 32'd1);
        chk("abort_code", {30'd0, err_code}, 32'd3);
        chk("abort_ov", {31'd0, overlay_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_wq", wq.size(), 32'd0);
        frame(16'h0020, 16'd4, 4, 8'h00, 1, 0, 2'd0);

        // reset for one cycle mid-payload
        send(8'hA5, 0, 0, 0);
        send(8'h40, 0, 0, 0);
        send(8'h00, 0, 0, 0);
        send(8'h03, 0, 0, 0);
        send(8'h00, 0, 0, 0);
        send(8'h11, 0, 1, 11'h040);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mrst_we", {31'd0, ram_we}, 32'd0);
        chk("mrst_ad", {21'd0, ram_ad}, 32'd0);
        chk("mrst_din", {24'd0, ram_din}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_code", {30'd0, err_code}, 32'd0);
        chk("mrst_ov", {31'd0, overlay_en}, 32'd0);
        send(8'h22, 0, 0, 0);
        send(8'h33, 0, 0, 0);
        send(8'h00, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        frame(16'h0300, 16'd5, 5, 8'h00, 2, 0, 2'd0);

        repeat (3) @(posedge clk);
        chk("final_wq", wq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
